pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Parametrised successor to the combinational next-PC mux.
- Owns the fetch PC register, drives the instruction-memory request handshake, and resolves D-stage control-flow with delay-slot semantics.
- Adds exception vectoring, ERET return, a one-entry pending-redirect latch for redirects that arrive while a fetch is outstanding or F is stalled, and fetch-address fault detection.
- Sits between the hazard unit, the D-stage comparator/decoder, the CP0 block and instruction memory.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- EXC_VEC, 32'h0000_4180, exception handler entry.
- IMEM_BASE, 32'h0000_3000, lowest legal fetch address.
- IMEM_BYTES, 16384, size of the legal fetch window in bytes; legal range is [IMEM_BASE, IMEM_BASE+IMEM_BYTES).
- BR_W, 4, width of the control-flow kind code.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- i_stall  in  1  hazard stall; F and D hold.
- i_branch  in  BR_W  D-stage kind: 0 none, 1 beq, 2 bne, 3 bgez, 4 bgtz, 5 blez, 6 bltz, 7 j, 8 jal, 9 jr, 10 jalr; other codes treated as none.
- i_cond  in  1  branch condition true; the comparator already folds polarity, so 1 means taken for every conditional kind.
- i_imm26  in  26  D-stage instruction index field.
- i_jr_addr  in  32  forwarded rs value for jr/jalr.
- i_pc4_d  in  32  PC+4 of the D-stage instruction.
- i_exc  in  1  exception request from CP0.
- i_eret  in  1  ERET request.
- i_epc  in  32  return address for ERET.
- o_imem_req  out  1  fetch request valid.
- i_imem_ready  in  1  instruction memory accepts/returns the request this cycle.
- o_pc  out  32  current fetch address.
- o_fetch_done  out  1  fetch completes this cycle (o_imem_req & i_imem_ready).
- o_busy  out  1  fetch outstanding (o_imem_req & ~i_imem_ready); fed to the hazard unit.
- o_adel  out  1  o_pc is misaligned (o_pc[1:0]!=0) or outside the fetch window.

Behaviour:
- Reset (synchronous): o_pc=RESET_PC, pending latch empty, o_imem_req=0, o_adel=0. o_imem_req rises to 1 in the first cycle after reset deasserts and stays 1 except during reset.
- Target arithmetic, all 32-bit wrap-around:
  - branch: i_pc4_d + sign_extend(i_imm26[15:0])<<2
  - j/jal: {i_pc4_d[31:28], i_imm26, 2'b00}
  - jr/jalr: i_jr_addr
  - sequential: o_pc+4
- D-stage redirect is valid when i_stall=0 and either i_branch is 7–10, or i_branch is 1–6 with i_cond=1. An untaken branch produces no redirect; fetch continues sequentially, because the delay slot is already in F.
- Redirect priority, highest first: exception (target EXC_VEC), ERET (target i_epc), pending latch, D-stage redirect, sequential.
- Exception and ERET are sampled on any cycle regardless of i_stall. If both are asserted together, the exception wins.
- PC advance happens only on a cycle with o_fetch_done=1 and i_stall=0. o_pc then loads the highest-priority target, and the pending latch clears unless a new redirect arrives in the same cycle.
  - If i_exc or i_eret is asserted in that cycle, o_pc loads its target directly.
  - A D-stage redirect in that cycle loads its target directly. The delay slot is the fetch completing now.
- On any cycle without a PC advance, a valid redirect is written into the pending latch (target plus 2-bit class: exc/eret/branch).
  - A new entry overwrites an existing one only if its class priority is higher or equal; a branch redirect never overwrites a pending exc or eret.
- An exception or ERET also discards any held branch redirect: the latch is overwritten, and a branch in the same cycle as an exception is dropped.
- Stall with no fetch: o_pc holds and o_imem_req stays 1; the memory may re-accept the same address.
- o_adel is registered, computed from the value being loaded into o_pc. The PC still loads the faulting address; CP0 decides the response. An exception redirect clears o_adel, because EXC_VEC is legal.
- Reset mid-fetch: the outstanding request is abandoned, the latch is cleared, and o_pc=RESET_PC next cycle.

Test Plan:
- Reset, then i_imem_ready=1 with no branches -> o_pc sequence 0x3000, 0x3004, 0x3008; o_imem_req=0 during reset.
- beq taken at D: i_pc4_d=0x3004, imm16=0x0003, i_cond=1, fetch done -> next o_pc=0x3010; bne with i_cond=0 -> o_pc=0x3008.
- jr while i_imem_ready=0 for 3 cycles: i_jr_addr=0x3400 -> target latched, o_busy=1 for 3 cycles, o_pc=0x3400 on the cycle after ready rises.
- Pending branch to 0x3400, then i_exc during the wait -> o_pc=0x4180; 0x3400 is never fetched. i_exc and i_eret together -> 0x4180.
- jr to 0x3402 -> o_pc=0x3402, o_adel=1. j to 0x0000_1000 (below IMEM_BASE) -> o_adel=1.
- i_stall=1 with a jal at D for 2 cycles -> no latch entry and o_pc held; the stall releases -> redirect taken once.

Source files
------------

// File: rtl/pc_fetch_if.sv
// Instruction-memory fetch handshake between the fetch unit (master) and instruction memory (slave).
interface pc_fetch_if;
    logic        o_imem_req;
    logic        i_imem_ready;
    logic [31:0] o_pc;
    logic        o_fetch_done;
    logic        o_busy;
    logic        o_adel;

    modport master (
        output o_imem_req,
        output o_pc,
        output o_fetch_done,
        output o_busy,
        output o_adel,
        input  i_imem_ready
    );

    modport slave (
        input  o_imem_req,
        input  o_pc,
        input  o_fetch_done,
        input  o_busy,
        input  o_adel,
        output i_imem_ready
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Fetch PC register with imem handshake, delay-slot control flow, exception/ERET vectoring,
// a one-entry pending-redirect latch and fetch-address fault detection.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC    = 32'h0000_4180,
    parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
    parameter int unsigned IMEM_BYTES = 16384,
    parameter int          BR_W       = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_stall,
    input  logic [BR_W-1:0] i_branch,
    input  logic            i_cond,
    input  logic [25:0]     i_imm26,
    input  logic [31:0]     i_jr_addr,
    input  logic [31:0]     i_pc4_d,
    input  logic            i_exc,
    input  logic            i_eret,
    input  logic [31:0]     i_epc,
    pc_fetch_if.master      io_imem
);

    typedef enum logic [1:0] {
        CLS_NONE = 2'd0,
        CLS_BR   = 2'd1,
        CLS_ERET = 2'd2,
        CLS_EXC  = 2'd3
    } redir_cls_t;

    logic [31:0] r_pc;
    logic        r_req;
    logic        r_adel;
    redir_cls_t  r_pend_cls;
    logic [31:0] r_pend_tgt;

    logic        w_fetch_done;
    logic        w_advance;
    logic        w_is_cond;
    logic        w_is_jump;
    logic        w_is_jreg;
    logic        w_d_valid;
    logic [31:0] w_d_target;
    redir_cls_t  w_new_cls;
    logic [31:0] w_new_tgt;
    logic [31:0] w_pc_next;
    logic [31:0] w_off;
    logic        w_adel_next;
    redir_cls_t  w_pend_cls_next;
    logic [31:0] w_pend_tgt_next;

    assign w_fetch_done = r_req & io_imem.i_imem_ready;
    assign w_advance    = w_fetch_done & ~i_stall;

    // Kinds 1-6 are conditional branches, 7/8 absolute jumps, 9/10 register jumps.
    assign w_is_cond = (i_branch >= BR_W'(1)) && (i_branch <= BR_W'(6));
    assign w_is_jump = (i_branch == BR_W'(7)) || (i_branch == BR_W'(8));
    assign w_is_jreg = (i_branch == BR_W'(9)) || (i_branch == BR_W'(10));
    assign w_d_valid = ~i_stall & (w_is_jump | w_is_jreg | (w_is_cond & i_cond));

    always_comb begin
        w_d_target = i_pc4_d + {{14{i_imm26[15]}}, i_imm26[15:0], 2'b00};
        if (w_is_jump) begin
            w_d_target = {i_pc4_d[31:28], i_imm26, 2'b00};
        end else if (w_is_jreg) begin
            w_d_target = i_jr_addr;
        end
    end

    // Highest-priority redirect arriving this cycle; exception beats ERET beats D-stage.
    always_comb begin
        w_new_cls = CLS_NONE;
        w_new_tgt = w_d_target;
        if (i_exc) begin
            w_new_cls = CLS_EXC;
            w_new_tgt = EXC_VEC;
        end else if (i_eret) begin
            w_new_cls = CLS_ERET;
            w_new_tgt = i_epc;
        end else if (w_d_valid) begin
            w_new_cls = CLS_BR;
        end
    end

    always_comb begin
        w_pc_next = r_pc + 32'd4;
        if (i_exc || i_eret) begin
            w_pc_next = w_new_tgt;
        end else if (r_pend_cls != CLS_NONE) begin
            w_pc_next = r_pend_tgt;
        end else if (w_d_valid) begin
            w_pc_next = w_d_target;
        end
    end

    // Window check relies on unsigned wrap: anything below IMEM_BASE becomes a huge offset.
    assign w_off       = w_pc_next - IMEM_BASE;
    assign w_adel_next = (w_pc_next[1:0] != 2'b00) || (w_off >= 32'(IMEM_BYTES));

    always_comb begin
        w_pend_cls_next = r_pend_cls;
        w_pend_tgt_next = r_pend_tgt;
        if (w_advance) begin
            // A D-stage redirect losing to a consumed pending entry is kept for the next fetch.
            if (!i_exc && !i_eret && (r_pend_cls != CLS_NONE) && w_d_valid) begin
                w_pend_cls_next = CLS_BR;
                w_pend_tgt_next = w_d_target;
            end else begin
                w_pend_cls_next = CLS_NONE;
            end
        end else if ((w_new_cls != CLS_NONE) && (w_new_cls >= r_pend_cls)) begin
            w_pend_cls_next = w_new_cls;
            w_pend_tgt_next = w_new_tgt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_req      <= 1'b0;
            r_adel     <= 1'b0;
            r_pend_cls <= CLS_NONE;
            r_pend_tgt <= 32'd0;
        end else begin
            r_req      <= 1'b1;
            r_pend_cls <= w_pend_cls_next;
            r_pend_tgt <= w_pend_tgt_next;
            if (w_advance) begin
                r_pc   <= w_pc_next;
                r_adel <= w_adel_next;
            end
        end
    end

    assign io_imem.o_imem_req   = r_req;
    assign io_imem.o_pc         = r_pc;
    assign io_imem.o_fetch_done = w_fetch_done;
    assign io_imem.o_busy       = r_req & ~io_imem.i_imem_ready;
    assign io_imem.o_adel       = r_adel;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Table-driven bench for pc_fetch_unit with a scoreboard of expected post-edge PC/fault state.
module tb_pc_fetch_unit;

    typedef struct {
        logic        stall;
        logic [3:0]  br;
        logic        cond;
        logic [25:0] imm;
        logic [31:0] jr;
        logic [31:0] pc4;
        logic        exc;
        logic        eret;
        logic [31:0] epc;
        logic        rdy;
        logic [31:0] e_pc;
        logic        e_adel;
        logic        e_busy;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_stall = 1'b0;
    logic [3:0]  i_branch = 4'd0;
    logic        i_cond = 1'b0;
    logic [25:0] i_imm26 = 26'd0;
    logic [31:0] i_jr_addr = 32'd0;
    logic [31:0] i_pc4_d = 32'd0;
    logic        i_exc = 1'b0;
    logic        i_eret = 1'b0;
    logic [31:0] i_epc = 32'd0;

    int checks = 0;
    int failures = 0;

    vec_t tbl[$];
    vec_t sb[$];

    pc_fetch_if imem_if ();

    pc_fetch_unit dut (
        .clk       (clk),
        .reset     (reset),
        .i_stall   (i_stall),
        .i_branch  (i_branch),
        .i_cond    (i_cond),
        .i_imm26   (i_imm26),
        .i_jr_addr (i_jr_addr),
        .i_pc4_d   (i_pc4_d),
        .i_exc     (i_exc),
        .i_eret    (i_eret),
        .i_epc     (i_epc),
        .io_imem   (imem_if.master)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic stall, logic [3:0] br, logic cond, logic [25:0] imm,
                                logic [31:0] jr, logic [31:0] pc4, logic exc, logic eret,
                                logic [31:0] epc, logic rdy, logic [31:0] e_pc,
                                logic e_adel, logic e_busy);
        vec_t v;
        v.stall = stall; v.br = br; v.cond = cond; v.imm = imm; v.jr = jr; v.pc4 = pc4;
        v.exc = exc; v.eret = eret; v.epc = epc; v.rdy = rdy;
        v.e_pc = e_pc; v.e_adel = e_adel; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        i_stall = 1'b0; i_branch = 4'd0; i_cond = 1'b0; i_imm26 = 26'd0;
        i_jr_addr = 32'd0; i_pc4_d = 32'd0; i_exc = 1'b0; i_eret = 1'b0; i_epc = 32'd0;
        imem_if.i_imem_ready = 1'b0;
    endtask

    task automatic apply(input int idx, input vec_t v);
        vec_t e;
        @(negedge clk);
        i_stall = v.stall; i_branch = v.br; i_cond = v.cond; i_imm26 = v.imm;
        i_jr_addr = v.jr; i_pc4_d = v.pc4; i_exc = v.exc; i_eret = v.eret; i_epc = v.epc;
        imem_if.i_imem_ready = v.rdy;
        sb.push_back(v);
        #1;
        chk("busy", {31'd0, imem_if.o_busy}, {31'd0, v.e_busy});
        chk("fetch_done", {31'd0, imem_if.o_fetch_done}, {31'd0, v.rdy});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("pc", imem_if.o_pc, e.e_pc);
        chk("adel", {31'd0, imem_if.o_adel}, {31'd0, e.e_adel});
        chk("imem_req", {31'd0, imem_if.o_imem_req}, 32'd1);
        $display("vec %0d: br=%0d exc=%0b eret=%0b rdy=%0b stall=%0b -> pc=0x%08h adel=%0b",
                 idx, v.br, v.exc, v.eret, v.rdy, v.stall, imem_if.o_pc, imem_if.o_adel);
    endtask

    initial begin
        //           stl br  c  imm       jr          pc4         exc eret epc         rdy e_pc        adel busy
        tbl.push_back(mk(0, 0, 0, 26'h0,   32'h0,      32'h0,      0, 0, 32'h0,      1, 32'h3004,    0, 0));
        tbl.push_back(mk(0, 2, 0, 26'h5,   32'h0,      32'h3008,   0, 0, 32'h0,      1, 32'h3008,    0, 0));
        tbl.push_back(mk(0, 1, 1, 26'h3,   32'h0,      32'h3004,   0, 0, 32'h0,      1, 32'h3010,    0, 0));
        tbl.push_back(mk(0, 9, 0, 26'h0,   32'h3400,   32'h3010,   0, 0, 32'h0,      0, 32'h3010,    0, 1));
        tbl.push_back(mk(0, 0, 0, 26'h0,   32'h0,      32'h0,      0, 0, 32'h0,      0, 32'h3010,    0, 1));
        tbl.push_back(mk(0, 0, 0, 26'h0,   32'h0,      32'h0,      0, 0, 32'h0,      0, 32'h3010,    0, 1));
        tbl.push_back(mk(0, 0, 0, 26'h0,   32'h0,      32'h0,      0, 0, 32'h0,      1, 32'h3400,    0, 0));
        tbl.push_back(mk(0, 0, 0, 26'h0,   32'h0,      32'h0,      0, 0, 32'h0,      1, 32'h3404,    0, 0));
        tbl.push_back(mk(0, 9, 0, 26'h0,   32'h3500,   32'h3408,   0, 0, 32'h0,      0, 32'h3404,    0, 1));
        tbl.push_back(mk(0, 0, 0, 26'h0,   32'h0,      32'h0,      1, 0, 32'h0,      0, 32'h3404,    0, 1));
        tbl.push_back(mk(0, 0, 0, 26'h0,   32'h0,      32'h0,      0, 0, 32'h0,      1, 32'h4180,    0, 0));
        tbl.push_back(mk(0, 0, 0, 26'h0,   32'h0,      32'h0,      0, 0, 32'h0,      1, 32'h4184,    0, 0));
        tbl.push_back(mk(0, 0, 0, 26'h0,   32'h0,      32'h0,      1, 1, 32'h3200,   1, 32'h4180,    0, 0));
        tbl.push_back(mk(0, 0, 0, 26'h0,   32'h0,      32'h0,      0, 1, 32'h3200,   1, 32'h3200,    0, 0));
        tbl.push_back(mk(0, 9, 0, 26'h0,   32'h3402,   32'h3204,   0, 0, 32'h0,      1, 32'h3402,    1, 0));
        tbl.push_back(mk(0, 0, 0, 26'h0,   32'h0,      32'h0,      0, 0, 32'h0,      1, 32'h3406,    1, 0));
        tbl.push_back(mk(0, 7, 0, 26'h400, 32'h0,      32'h3408,   0, 0, 32'h0,      1, 32'h1000,    1, 0));
        tbl.push_back(mk(0, 10,0, 26'h0,   32'h3000,   32'h1004,   0, 0, 32'h0,      1, 32'h3000,    0, 0));
        tbl.push_back(mk(1, 8, 0, 26'hC40, 32'h0,      32'h3004,   0, 0, 32'h0,      1, 32'h3000,    0, 0));
        tbl.push_back(mk(1, 8, 0, 26'hC40, 32'h0,      32'h3004,   0, 0, 32'h0,      1, 32'h3000,    0, 0));
        tbl.push_back(mk(0, 8, 0, 26'hC40, 32'h0,      32'h3004,   0, 0, 32'h0,      1, 32'h3100,    0, 0));
        tbl.push_back(mk(0, 0, 0, 26'h0,   32'h0,      32'h0,      0, 0, 32'h0,      1, 32'h3104,    0, 0));
        tbl.push_back(mk(1, 0, 0, 26'h0,   32'h0,      32'h0,      1, 0, 32'h0,      0, 32'h3104,    0, 1));
        tbl.push_back(mk(0, 0, 0, 26'h0,   32'h0,      32'h0,      0, 0, 32'h0,      1, 32'h4180,    0, 0));
        tbl.push_back(mk(0, 0, 0, 26'h0,   32'h0,      32'h0,      0, 1, 32'h3300,   0, 32'h4180,    0, 1));
        tbl.push_back(mk(0, 9, 0, 26'h0,   32'h3600,   32'h4184,   0, 0, 32'h0,      0, 32'h4180,    0, 1));
        tbl.push_back(mk(0, 0, 0, 26'h0,   32'h0,      32'h0,      0, 0, 32'h0,      1, 32'h3300,    0, 0));
        tbl.push_back(mk(0, 0, 0, 26'h0,   32'h0,      32'h0,      0, 0, 32'h0,      1, 32'h3304,    0, 0));
        tbl.push_back(mk(0, 3, 1, 26'hFFFE,32'h0,      32'h3308,   0, 0, 32'h0,      1, 32'h3300,    0, 0));
        tbl.push_back(mk(0, 11,1, 26'h10,  32'h5000,   32'h3304,   0, 0, 32'h0,      1, 32'h3304,    0, 0));
        tbl.push_back(mk(0, 9, 0, 26'h0,   32'h6FFC,   32'h3308,   0, 0, 32'h0,      1, 32'h6FFC,    0, 0));
        tbl.push_back(mk(0, 9, 0, 26'h0,   32'h7000,   32'h7000,   0, 0, 32'h0,      1, 32'h7000,    1, 0));
        tbl.push_back(mk(0, 9, 0, 26'h0,   32'h3400,   32'h7004,   1, 0, 32'h0,      1, 32'h4180,    0, 0));
        tbl.push_back(mk(0, 0, 0, 26'h0,   32'h0,      32'h0,      0, 0, 32'h0,      1, 32'h4184,    0, 0));

        drive_idle();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_req", {31'd0, imem_if.o_imem_req}, 32'd0);
        chk("reset_pc", imem_if.o_pc, 32'h0000_3000);
        chk("reset_adel", {31'd0, imem_if.o_adel}, 32'd0);
        $display("reset: pc=0x%08h req=%0b", imem_if.o_pc, imem_if.o_imem_req);

        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_reset_req", {31'd0, imem_if.o_imem_req}, 32'd1);
        chk("post_reset_pc", imem_if.o_pc, 32'h0000_3000);
        $display("release: pc=0x%08h req=%0b", imem_if.o_pc, imem_if.o_imem_req);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(i, tbl[i]);
        end

        // Reset while a jr is pending: latch must be abandoned.
        apply(100, mk(0, 9, 0, 26'h0, 32'h3400, 32'h4188, 0, 0, 32'h0, 0, 32'h4184, 0, 1));
        @(negedge clk);
        drive_idle();
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midfetch_reset_pc", imem_if.o_pc, 32'h0000_3000);
        chk("midfetch_reset_req", {31'd0, imem_if.o_imem_req}, 32'd0);
        $display("mid-fetch reset: pc=0x%08h req=%0b", imem_if.o_pc, imem_if.o_imem_req);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("midfetch_release_req", {31'd0, imem_if.o_imem_req}, 32'd1);
        apply(101, mk(0, 0, 0, 26'h0, 32'h0, 32'h0, 0, 0, 32'h0, 1, 32'h3004, 0, 0));

        // Stall while memory is busy: no advance even when ready rises under stall.
        apply(102, mk(1, 0, 0, 26'h0, 32'h0, 32'h0, 0, 0, 32'h0, 0, 32'h3004, 0, 1));
        apply(103, mk(1, 0, 0, 26'h0, 32'h0, 32'h0, 0, 0, 32'h0, 1, 32'h3004, 0, 0));
        apply(104, mk(0, 0, 0, 26'h0, 32'h0, 32'h0, 0, 0, 32'h0, 1, 32'h3008, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
